module_bin_bcd: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one shift per clock.
- Sits directly upstream of the 7-segment multiplexer.
- Drives its unidades/decenas/centenas/millares digit inputs and its listo qualifier.
- Converts a captured binary value up to 9999 into four registered BCD digits. Out-of-range inputs are flagged.

---
 rtl/module_bin_bcd_pkg.sv | 7 +
 rtl/module_bin_bcd_add3.sv | 7 +
 rtl/module_bin_bcd.sv | 77 +++++++
 tb/tb_module_bin_bcd.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/module_bin_bcd_pkg.sv
// pkg_bin_bcd: shared FSM states and constants for the binary-to-BCD converter
package pkg_bin_bcd;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int MAX_BCD = 9999;
  localparam logic [3:0] OVF_DIGIT = 4'hF;
  localparam int BCD_DIGITS = 4;
endpackage

// File: rtl/module_bin_bcd_add3.sv
// module_add3: double-dabble nibble correction, adds 3 when the digit is 5 or more
module module_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

// File: rtl/module_bin_bcd.sv
// module_bin_bcd: sequential double-dabble converter, one shift per clock,
// feeding four registered BCD digits and a one-cycle listo pulse to the display
module module_bin_bcd
  import pkg_bin_bcd::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin_input,
  input  logic             start,
  output logic [3:0]       unidades,
  output logic [3:0]       decenas,
  output logic [3:0]       centenas,
  output logic [3:0]       millares,
  output logic             listo,
  output logic             busy,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * BCD_DIGITS + WIDTH;
  state_t        r_state;
  logic [SW-1:0] r_sr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic [SW-1:0] w_corr;
  // only the BCD nibbles are corrected; the binary tail passes through untouched
  assign w_corr[WIDTH-1:0] = r_sr[WIDTH-1:0];
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    module_add3 u_add3 (
      .i_nib(r_sr[WIDTH + 4*g +: 4]),
      .o_nib(w_corr[WIDTH + 4*g +: 4])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      unidades <= 4'd0;
      decenas  <= 4'd0;
      centenas <= 4'd0;
      millares <= 4'd0;
      listo    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_sr    <= {{(4*BCD_DIGITS){1'b0}}, bin_input};
          r_cnt   <= '0;
          r_ovf   <= 32'(bin_input) > MAX_BCD;
          r_state <= SHIFT;
          busy    <= 1'b1;
        end
        SHIFT: begin
          r_sr    <= w_corr << 1;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == CW'(WIDTH - 1)) ? DONE : SHIFT;
        end
        DONE: begin
          unidades <= r_ovf ? OVF_DIGIT : r_sr[WIDTH +: 4];
          decenas  <= r_ovf ? OVF_DIGIT : r_sr[WIDTH + 4 +: 4];
          centenas <= r_ovf ? OVF_DIGIT : r_sr[WIDTH + 8 +: 4];
          millares <= r_ovf ? OVF_DIGIT : r_sr[WIDTH + 12 +: 4];
          overflow <= r_ovf;
          listo    <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_module_bin_bcd.sv
// tb_module_bin_bcd: table vectors plus corner sequences, checked through a listo-driven scoreboard
module tb_module_bin_bcd;
  typedef struct {logic [13:0] bin; logic [15:0] dig; logic ovf;} vec_t;
  typedef struct {logic [15:0] dig; logic ovf; int cyc;} exp_t;
  logic clk = 0, rst = 1, start = 0, start8 = 0;
  logic [13:0] bin_input = '0;
  logic [7:0] bin8 = '0;
  logic [3:0] u, d, c, m, u8, d8, c8, m8;
  logic listo, busy, overflow, listo8, busy8, overflow8;
  logic [15:0] dig, dig8;
  int checks = 0, errors = 0, cyc = 0, bcnt = 0;
  exp_t q[$];
  exp_t mon_e;
  vec_t vecs[10];
  assign dig  = {m, c, d, u};
  assign dig8 = {m8, c8, d8, u8};

  module_bin_bcd #(.WIDTH(14)) dut (
    .clk(clk), .rst(rst), .bin_input(bin_input), .start(start),
    .unidades(u), .decenas(d), .centenas(c), .millares(m),
    .listo(listo), .busy(busy), .overflow(overflow));
  module_bin_bcd #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .bin_input(bin8), .start(start8),
    .unidades(u8), .decenas(d8), .centenas(c8), .millares(m8),
    .listo(listo8), .busy(busy8), .overflow(overflow8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // caller is positioned at a negedge; start is held for exactly one edge
  task automatic do_start(input logic [13:0] b, input logic [15:0] dd, input logic o);
    exp_t e;
    bin_input = b;
    start = 1;
    e.dig = dd;
    e.ovf = o;
    e.cyc = cyc;
    q.push_back(e);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && q.size() > 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (rst) bcnt = 0;
    else if (listo) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_listo actual=1 required=0 at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("digits", dig, mon_e.dig);
        chk("overflow", overflow, mon_e.ovf);
        chk("latency", cyc - mon_e.cyc, 16);
        chk("busy_cycles", bcnt, 15);
      end
      bcnt = 0;
    end else if (busy) bcnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int s;
    logic changed;
    vecs[0] = '{14'd0,     16'h0000, 1'b0};
    vecs[1] = '{14'd1234,  16'h1234, 1'b0};
    vecs[2] = '{14'd9,     16'h0009, 1'b0};
    vecs[3] = '{14'd10,    16'h0010, 1'b0};
    vecs[4] = '{14'd99,    16'h0099, 1'b0};
    vecs[5] = '{14'd100,   16'h0100, 1'b0};
    vecs[6] = '{14'd5000,  16'h5000, 1'b0};
    vecs[7] = '{14'd16383, 16'hFFFF, 1'b1};
    vecs[8] = '{14'd7,     16'h0007, 1'b0};
    vecs[9] = '{14'd10000, 16'hFFFF, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_digits", dig, 16'h0000);
    chk("rst_listo", listo, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_digits8", dig8, 16'h0000);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      do_start(vecs[i].bin, vecs[i].dig, vecs[i].ovf);
      wait_idle(40);
    end
    // hold: digits stay put without a new start
    do_start(14'd1234, 16'h1234, 1'b0);
    wait_idle(40);
    changed = 0;
    repeat (50) begin
      @(negedge clk);
      if (dig !== 16'h1234 || overflow !== 1'b0) changed = 1;
    end
    chk("hold_stable", changed, 1'b0);
    // back-to-back: second start lands in the listo cycle
    do_start(14'd9999, 16'h9999, 1'b0);
    for (int i = 0; i < 40 && !listo; i++) @(negedge clk);
    chk("b2b_first_listo", listo, 1'b1);
    do_start(14'd10000, 16'hFFFF, 1'b1);
    chk("b2b_listo_drop", listo, 1'b0);
    wait_idle(40);
    // start while busy is ignored
    do_start(14'd4321, 16'h4321, 1'b0);
    repeat (4) @(negedge clk);
    chk("busy_mid", busy, 1'b1);
    bin_input = 14'd555;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_idle(40);
    repeat (20) @(negedge clk);
    chk("ignored_digits", dig, 16'h4321);
    // asynchronous reset mid-conversion
    do_start(14'd8765, 16'h8765, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_digits", dig, 16'h0000);
    chk("async_rst_busy", busy, 1'b0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (25) @(negedge clk);
    chk("no_listo_after_rst", dig, 16'h0000);
    do_start(14'd42, 16'h0042, 1'b0);
    wait_idle(40);
    // narrow instance
    bin8 = 8'd255;
    start8 = 1;
    s = cyc;
    @(negedge clk);
    start8 = 0;
    for (int i = 0; i < 30 && !listo8; i++) @(negedge clk);
    chk("w8_listo", listo8, 1'b1);
    chk("w8_latency", cyc - s, 10);
    chk("w8_digits", dig8, 16'h0255);
    chk("w8_overflow", overflow8, 1'b0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
